// File: rtl/tinyriscv_ex_ctrl_if.sv
// rtl/tinyriscv_ex_ctrl_if.sv - decode/ALU/writeback bundle for the execute-stage controller
// master is the controller side; slave is the surrounding pipeline (decode, ALU, mem stage).
`ifndef RISCV_CONFIG_XLEN
`define RISCV_CONFIG_XLEN 32
`endif

interface tinyriscv_ex_ctrl_if #(parameter int XLEN = `RISCV_CONFIG_XLEN);
   logic            id_valid;
   logic            id_ready;
   logic [6:0]      id_opcode;
   logic [2:0]      id_funct3;
   logic [4:0]      id_funct7;
   logic [XLEN-1:0] id_op1;
   logic [XLEN-1:0] id_op2;
   logic [XLEN-1:0] id_op3;
   logic [XLEN-1:0] id_pc;
   logic [4:0]      id_rd;
   logic [6:0]      alu_opcode;
   logic [2:0]      alu_funct3;
   logic [4:0]      alu_funct7;
   logic [XLEN-1:0] alu_op_1;
   logic [XLEN-1:0] alu_op_2;
   logic [XLEN-1:0] alu_op_3;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] alu_byp;
   logic            alu_exc;
   logic            ex_valid;
   logic            ex_ready;
   logic [XLEN-1:0] ex_res;
   logic [XLEN-1:0] ex_byp;
   logic [4:0]      ex_rd;
   logic [6:0]      ex_opcode;
   logic [2:0]      ex_funct3;
   logic            br_taken;
   logic [XLEN-1:0] br_target;
   logic            exc_valid;
   logic [XLEN-1:0] exc_pc;
   logic [1:0]      exc_cause;

   modport master (
      input  id_valid, id_opcode, id_funct3, id_funct7, id_op1, id_op2, id_op3, id_pc, id_rd,
      input  alu_res, alu_byp, alu_exc, ex_ready,
      output id_ready, alu_opcode, alu_funct3, alu_funct7, alu_op_1, alu_op_2, alu_op_3,
      output ex_valid, ex_res, ex_byp, ex_rd, ex_opcode, ex_funct3,
      output br_taken, br_target, exc_valid, exc_pc, exc_cause
   );

   modport slave (
      output id_valid, id_opcode, id_funct3, id_funct7, id_op1, id_op2, id_op3, id_pc, id_rd,
      output alu_res, alu_byp, alu_exc, ex_ready,
      input  id_ready, alu_opcode, alu_funct3, alu_funct7, alu_op_1, alu_op_2, alu_op_3,
      input  ex_valid, ex_res, ex_byp, ex_rd, ex_opcode, ex_funct3,
      input  br_taken, br_target, exc_valid, exc_pc, exc_cause
   );
endinterface

// File: rtl/tinyriscv_ex_ctrl.sv
// rtl/tinyriscv_ex_ctrl.sv - TinyRiscV execute-stage controller
// Drives the combinational ALU, holds a one-entry result slot, emits redirect pulses and traps.
`ifndef RISCV_CONFIG_XLEN
`define RISCV_CONFIG_XLEN 32
`endif

module tinyriscv_ex_ctrl #(
   parameter int XLEN = `RISCV_CONFIG_XLEN
) (
   input logic                 clk,
   input logic                 rst,
   input logic                 flush,
   tinyriscv_ex_ctrl_if.master bus
);
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {ST_RUN, ST_REDIR, ST_HALT} state_t;

   state_t          r_state;
   logic            r_ex_valid;
   logic [XLEN-1:0] r_ex_res;
   logic [XLEN-1:0] r_ex_byp;
   logic [4:0]      r_ex_rd;
   logic [6:0]      r_ex_opcode;
   logic [2:0]      r_ex_funct3;
   logic            r_br_taken;
   logic [XLEN-1:0] r_br_target;
   logic            r_exc_valid;
   logic [XLEN-1:0] r_exc_pc;
   logic [1:0]      r_exc_cause;

   logic            w_id_ready;
   logic            w_accept;
   logic            w_is_fwd;
   logic            w_is_br;
   logic            w_is_jmp;
   logic            w_is_sys;
   logic            w_trap;
   logic            w_load;
   logic            w_redirect;
   logic [XLEN-1:0] w_br_target;

   assign bus.alu_opcode = bus.id_opcode;
   assign bus.alu_funct3 = bus.id_funct3;
   assign bus.alu_funct7 = bus.id_funct7;
   assign bus.alu_op_1   = bus.id_op1;
   assign bus.alu_op_2   = bus.id_op2;
   assign bus.alu_op_3   = bus.id_op3;

   assign w_id_ready = !rst && (r_state == ST_RUN) && (!r_ex_valid || bus.ex_ready) && !flush;
   assign w_accept   = bus.id_valid && w_id_ready;

   assign w_is_fwd = (bus.id_opcode == OPC_OP)    || (bus.id_opcode == OPC_OPIMM) ||
                     (bus.id_opcode == OPC_LOAD)  || (bus.id_opcode == OPC_STORE) ||
                     (bus.id_opcode == OPC_LUI)   || (bus.id_opcode == OPC_AUIPC);
   assign w_is_br  = (bus.id_opcode == OPC_BRANCH);
   assign w_is_jmp = (bus.id_opcode == OPC_JAL) || (bus.id_opcode == OPC_JALR);
   assign w_is_sys = (bus.id_opcode == OPC_SYSTEM);

   // Any ALU exception turns the operation into a trap, whatever its class.
   assign w_trap     = w_accept && (bus.alu_exc || w_is_sys);
   assign w_load     = w_accept && !bus.alu_exc && (w_is_fwd || w_is_jmp);
   assign w_redirect = w_accept && !bus.alu_exc && (w_is_jmp || (w_is_br && bus.alu_res[0]));
   assign w_br_target = w_is_jmp ? {bus.alu_res[XLEN-1:1], 1'b0} : bus.id_pc + bus.alu_byp;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_ex_valid  <= 1'b0;
         r_ex_res    <= '0;
         r_ex_byp    <= '0;
         r_ex_rd     <= '0;
         r_ex_opcode <= '0;
         r_ex_funct3 <= '0;
         r_br_taken  <= 1'b0;
         r_br_target <= '0;
         r_exc_valid <= 1'b0;
         r_exc_pc    <= '0;
         r_exc_cause <= '0;
      end else if (flush) begin
         r_state     <= ST_RUN;
         r_ex_valid  <= 1'b0;
         r_br_taken  <= 1'b0;
         r_exc_valid <= 1'b0;
      end else begin
         r_br_taken <= w_redirect;
         if (w_load) begin
            r_ex_valid  <= 1'b1;
            r_ex_res    <= w_is_jmp ? bus.alu_byp : bus.alu_res;
            r_ex_byp    <= w_is_jmp ? '0 : bus.alu_byp;
            r_ex_rd     <= bus.id_rd;
            r_ex_opcode <= bus.id_opcode;
            r_ex_funct3 <= bus.id_funct3;
         end else if (r_ex_valid && bus.ex_ready) begin
            r_ex_valid <= 1'b0;
         end
         if (w_redirect) begin
            r_br_target <= w_br_target;
         end
         if (w_trap) begin
            r_exc_valid <= 1'b1;
            r_exc_pc    <= bus.id_pc;
            r_exc_cause <= bus.alu_exc ? 2'd0 : 2'd1;
         end
         case (r_state)
            ST_RUN: begin
               if (w_trap) begin
                  r_state <= ST_HALT;
               end else if (w_redirect) begin
                  r_state <= ST_REDIR;
               end
            end
            ST_REDIR: r_state <= ST_RUN;
            ST_HALT:  r_state <= ST_HALT;
            default:  r_state <= ST_RUN;
         endcase
      end
   end

   assign bus.id_ready  = w_id_ready;
   assign bus.ex_valid  = r_ex_valid;
   assign bus.ex_res    = r_ex_res;
   assign bus.ex_byp    = r_ex_byp;
   assign bus.ex_rd     = r_ex_rd;
   assign bus.ex_opcode = r_ex_opcode;
   assign bus.ex_funct3 = r_ex_funct3;
   assign bus.br_taken  = r_br_taken;
   assign bus.br_target = r_br_target;
   assign bus.exc_valid = r_exc_valid;
   assign bus.exc_pc    = r_exc_pc;
   assign bus.exc_cause = r_exc_cause;
endmodule

// File: tb/tb_tinyriscv_ex_ctrl.sv
// tb/tb_tinyriscv_ex_ctrl.sv - bench for tinyriscv_ex_ctrl
// Vector table for the pipelined flow, hand sequences for traps, flush and reset.
module tb_tinyriscv_ex_ctrl;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef struct {
      logic        v;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        rdy;
      logic        e_idr;
      logic        e_exv;
      logic [31:0] e_res;
      logic [31:0] e_byp;
      logic [4:0]  e_rd;
      logic        e_br;
      logic [31:0] e_tgt;
   } vec_t;

   logic clk;
   logic rst;
   logic flush;
   logic force_exc;
   int   n_checks;
   int   n_fail;
   vec_t vt[13];

   tinyriscv_ex_ctrl_if #(.XLEN(32)) bus ();

   tinyriscv_ex_ctrl #(.XLEN(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: add/xor/or/and, BEQ/BNE compare, jumps compute target in res and link in byp.
   always_comb begin
      bus.alu_res = '0;
      bus.alu_byp = bus.alu_op_3;
      bus.alu_exc = force_exc;
      case (bus.alu_opcode)
         OPC_OP, OPC_OPIMM: begin
            case (bus.alu_funct3)
               3'd0:    bus.alu_res = bus.alu_op_1 + bus.alu_op_2;
               3'd4:    bus.alu_res = bus.alu_op_1 ^ bus.alu_op_2;
               3'd6:    bus.alu_res = bus.alu_op_1 | bus.alu_op_2;
               3'd7:    bus.alu_res = bus.alu_op_1 & bus.alu_op_2;
               default: bus.alu_exc = 1'b1;
            endcase
         end
         OPC_BRANCH: begin
            case (bus.alu_funct3)
               3'd0:    bus.alu_res = {31'd0, bus.alu_op_1 == bus.alu_op_2};
               3'd1:    bus.alu_res = {31'd0, bus.alu_op_1 != bus.alu_op_2};
               default: bus.alu_exc = 1'b1;
            endcase
         end
         OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC:
            bus.alu_res = bus.alu_op_1 + bus.alu_op_2;
         default: bus.alu_res = '0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] pc, input logic [4:0] rd, input logic rdy);
      bus.id_valid  = v;
      bus.id_opcode = opc;
      bus.id_funct3 = f3;
      bus.id_funct7 = '0;
      bus.id_op1    = a;
      bus.id_op2    = b;
      bus.id_op3    = c;
      bus.id_pc     = pc;
      bus.id_rd     = rd;
      bus.ex_ready  = rdy;
   endtask

   function automatic vec_t mkv(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                input logic [31:0] pc, input logic [4:0] rd, input logic rdy,
                                input logic e_idr, input logic e_exv, input logic [31:0] e_res,
                                input logic [31:0] e_byp, input logic [4:0] e_rd,
                                input logic e_br, input logic [31:0] e_tgt);
      vec_t r;
      r.v = v; r.opc = opc; r.f3 = f3; r.a = a; r.b = b; r.c = c; r.pc = pc; r.rd = rd;
      r.rdy = rdy; r.e_idr = e_idr; r.e_exv = e_exv; r.e_res = e_res; r.e_byp = e_byp;
      r.e_rd = e_rd; r.e_br = e_br; r.e_tgt = e_tgt;
      return r;
   endfunction

   task automatic trap_flush();
      @(negedge clk);
      flush = 1'b1;
      drive(1'b0, OPC_OP, 3'd0, 0, 0, 0, 0, 0, 1'b1);
      @(posedge clk); #1;
      chk("flush_clears_exc", {31'd0, bus.exc_valid}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("run_after_flush_idr", {31'd0, bus.id_ready}, 32'd1);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      force_exc = 1'b0;
      drive(1'b0, 7'd0, 3'd0, 0, 0, 0, 0, 0, 1'b0);

      vt[0]  = mkv(1, OPC_OP,     0, 5,       7, 0,     0,     1, 1, 1, 1, 12,    0,     1, 0, 0);
      vt[1]  = mkv(1, OPC_OP,     4, 'hF0, 'hFF, 0,     4,     2, 1, 1, 1, 'h0F,  0,     2, 0, 0);
      vt[2]  = mkv(1, OPC_OP,     0, 1,       2, 0,     8,     3, 0, 0, 1, 'h0F,  0,     2, 0, 0);
      vt[3]  = mkv(1, OPC_OP,     0, 1,       2, 0,     8,     3, 0, 0, 1, 'h0F,  0,     2, 0, 0);
      vt[4]  = mkv(1, OPC_OP,     0, 1,       2, 0,     8,     3, 1, 1, 1, 3,     0,     3, 0, 0);
      vt[5]  = mkv(0, OPC_OP,     0, 0,       0, 0,     0,     0, 1, 1, 0, 3,     0,     3, 0, 0);
      vt[6]  = mkv(1, OPC_BRANCH, 0, 3,       3, 'h20,  'h100, 0, 1, 1, 0, 3,     0,     3, 1, 'h120);
      vt[7]  = mkv(1, OPC_BRANCH, 0, 3,       3, 'h20,  'h100, 0, 1, 0, 0, 3,     0,     3, 0, 0);
      vt[8]  = mkv(1, OPC_BRANCH, 0, 3,       4, 'h20,  'h100, 0, 1, 1, 0, 3,     0,     3, 0, 0);
      vt[9]  = mkv(1, OPC_OP,     0, 10,     20, 'h55,  'h104, 4, 1, 1, 1, 30,    'h55,  4, 0, 0);
      vt[10] = mkv(1, OPC_JALR,   0, 'h2000,  3, 'h104, 'h200, 5, 1, 1, 1, 'h104, 0,     5, 1, 'h2002);
      vt[11] = mkv(0, OPC_OP,     0, 0,       0, 0,     0,     0, 1, 0, 0, 'h104, 0,     5, 0, 0);
      vt[12] = mkv(0, OPC_OP,     0, 0,       0, 0,     0,     0, 1, 1, 0, 'h104, 0,     5, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("rst_ex_res", bus.ex_res, 32'd0);
      chk("rst_br_taken", {31'd0, bus.br_taken}, 32'd0);
      chk("rst_exc_valid", {31'd0, bus.exc_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         if (i != 0) @(negedge clk);
         drive(vt[i].v, vt[i].opc, vt[i].f3, vt[i].a, vt[i].b, vt[i].c, vt[i].pc, vt[i].rd, vt[i].rdy);
         #1;
         chk($sformatf("v%0d_id_ready", i), {31'd0, bus.id_ready}, {31'd0, vt[i].e_idr});
         chk($sformatf("v%0d_alu_op_1", i), bus.alu_op_1, vt[i].a);
         @(posedge clk); #1;
         chk($sformatf("v%0d_ex_valid", i), {31'd0, bus.ex_valid}, {31'd0, vt[i].e_exv});
         chk($sformatf("v%0d_ex_res", i), bus.ex_res, vt[i].e_res);
         chk($sformatf("v%0d_ex_byp", i), bus.ex_byp, vt[i].e_byp);
         chk($sformatf("v%0d_ex_rd", i), {27'd0, bus.ex_rd}, {27'd0, vt[i].e_rd});
         chk($sformatf("v%0d_br_taken", i), {31'd0, bus.br_taken}, {31'd0, vt[i].e_br});
         chk($sformatf("v%0d_exc_valid", i), {31'd0, bus.exc_valid}, 32'd0);
         if (vt[i].e_br) chk($sformatf("v%0d_br_target", i), bus.br_target, vt[i].e_tgt);
      end

      // Illegal funct3 trap, then a held-off decode for 10 cycles.
      @(negedge clk);
      drive(1'b1, OPC_OP, 3'd1, 1, 1, 0, 'h40, 9, 1'b1);
      @(posedge clk); #1;
      chk("trap_exc_valid", {31'd0, bus.exc_valid}, 32'd1);
      chk("trap_exc_pc", bus.exc_pc, 32'h40);
      chk("trap_exc_cause", {30'd0, bus.exc_cause}, 32'd0);
      chk("trap_no_forward", {31'd0, bus.ex_valid}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(1'b1, OPC_OP, 3'd0, 1, 1, 0, 'h44, 9, 1'b1);
         #1;
         chk($sformatf("halt%0d_id_ready", i), {31'd0, bus.id_ready}, 32'd0);
         chk($sformatf("halt%0d_exc_valid", i), {31'd0, bus.exc_valid}, 32'd1);
      end
      trap_flush();

      @(negedge clk);
      drive(1'b1, OPC_SYSTEM, 3'd0, 0, 0, 0, 'h80, 0, 1'b1);
      @(posedge clk); #1;
      chk("sys_exc_valid", {31'd0, bus.exc_valid}, 32'd1);
      chk("sys_exc_pc", bus.exc_pc, 32'h80);
      chk("sys_exc_cause", {30'd0, bus.exc_cause}, 32'd1);
      trap_flush();

      @(negedge clk);
      force_exc = 1'b1;
      drive(1'b1, OPC_SYSTEM, 3'd0, 0, 0, 0, 'h84, 0, 1'b1);
      @(posedge clk); #1;
      chk("sysexc_exc_pc", bus.exc_pc, 32'h84);
      chk("sysexc_cause_priority", {30'd0, bus.exc_cause}, 32'd0);
      @(negedge clk);
      force_exc = 1'b0;
      trap_flush();

      // Flush against a taken branch with the slot full.
      @(negedge clk);
      drive(1'b1, OPC_OP, 3'd0, 1, 1, 0, 'h300, 6, 1'b0);
      @(posedge clk); #1;
      chk("fp_slot_full", {31'd0, bus.ex_valid}, 32'd1);
      @(negedge clk);
      flush = 1'b1;
      drive(1'b1, OPC_BRANCH, 3'd0, 3, 3, 'h20, 'h100, 0, 1'b1);
      #1;
      chk("fp_id_ready", {31'd0, bus.id_ready}, 32'd0);
      @(posedge clk); #1;
      chk("fp_br_taken", {31'd0, bus.br_taken}, 32'd0);
      chk("fp_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("fp_ex_res_kept", bus.ex_res, 32'd2);
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, OPC_OP, 3'd0, 0, 0, 0, 0, 0, 1'b1);
      @(posedge clk); #1;
      chk("fp_no_late_redirect", {31'd0, bus.br_taken}, 32'd0);
      chk("fp_br_target_kept", bus.br_target, 32'h2002);

      // Reset in the middle of backpressure.
      @(negedge clk);
      drive(1'b1, OPC_OP, 3'd0, 9, 9, 0, 'h400, 7, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rb_id_ready", {31'd0, bus.id_ready}, 32'd0);
      chk("rb_ex_res", bus.ex_res, 32'd18);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rb_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("rb_ex_res_zero", bus.ex_res, 32'd0);
      chk("rb_ex_rd_zero", {27'd0, bus.ex_rd}, 32'd0);
      chk("rb_ex_opcode_zero", {25'd0, bus.ex_opcode}, 32'd0);
      chk("rb_br_target_zero", bus.br_target, 32'd0);
      chk("rb_exc_pc_zero", bus.exc_pc, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, OPC_OP, 3'd0, 0, 0, 0, 0, 0, 1'b0);
      #1;
      chk("rb_id_ready_after", {31'd0, bus.id_ready}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
